skid_fifo: RTL

SKID_FIFO -- requirements
Module: skid_fifo

---
 rtl/skid_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/skid_fifo.sv
// Registered-output FIFO with flush and registered occupancy count.
// Every output is decoded from registers, so no input reaches an output combinationally.
module skid_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_in_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [WIDTH-1:0]           o_out_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // S_INIT keeps the input closed for one cycle after reset is released.
    typedef enum logic [1:0] {
        S_INIT,
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign push = i_in_valid & o_in_ready;
    assign pop  = o_out_valid & i_out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_flush || state == S_INIT) begin
            state_next = S_EMPTY;
        end else if (count_next == '0) begin
            state_next = S_EMPTY;
        end else if (count_next == FULL_CNT) begin
            state_next = S_FULL;
        end else begin
            state_next = S_PARTIAL;
        end
    end

    always_comb begin
        o_in_ready  = (state == S_EMPTY) || (state == S_PARTIAL);
        o_out_valid = (state == S_PARTIAL) || (state == S_FULL);
    end

    // Flush and reset only rewind the bookkeeping; stored words are left as-is.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push && !i_reset && !i_flush) begin
            mem[wr_ptr] <= i_in_data;
        end
    end

    assign o_out_data = mem[rd_ptr];
    assign o_count    = count;

endmodule
